// File: rtl/i2s_clkgen_pkg.sv
// Shared encodings and slot/WS helpers for the I2S master clock generator.
package i2s_clkgen_pkg;

  localparam logic [1:0] I2S_FMT_I2S = 2'b00;
  localparam logic [1:0] I2S_FMT_LJ  = 2'b01;

  localparam logic [1:0] I2S_DAT_8_BITS  = 2'b00;
  localparam logic [1:0] I2S_DAT_16_BITS = 2'b01;
  localparam logic [1:0] I2S_DAT_24_BITS = 2'b10;
  localparam logic [1:0] I2S_DAT_32_BITS = 2'b11;

  typedef enum logic [1:0] {
    I2S_CLKGEN_IDLE = 2'b00,
    I2S_CLKGEN_RUN  = 2'b01,
    I2S_CLKGEN_STOP = 2'b10
  } state_t;

  // Index of the last slot in a frame, 2N-1.
  function automatic logic [5:0] slot_last(input logic [1:0] chl);
    logic [5:0] r;
    case (chl)
      I2S_DAT_8_BITS:  r = 6'd15;
      I2S_DAT_16_BITS: r = 6'd31;
      I2S_DAT_24_BITS: r = 6'd47;
      default:         r = 6'd63;
    endcase
    return r;
  endfunction

  // WS pin level for slot k. Left level is 1 in LJ, 0 in I2S; I2S leads by one slot.
  function automatic logic ws_level(input logic lj, input logic [5:0] k,
                                    input logic [5:0] last);
    logic [5:0] half;
    logic [5:0] kp;
    half = {1'b0, last[5:1]} + 6'd1;
    kp   = (k == last) ? 6'd0 : k + 6'd1;
    return lj ? (k < half) : !(kp < half);
  endfunction

endpackage

// File: rtl/i2s_clkgen_if.sv
// Control inputs and clock/strobe outputs of the I2S clock generator.
interface i2s_clkgen_if
  import i2s_clkgen_pkg::*;
#(
  parameter int DIV_WIDTH = 16
);
  logic                 en_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic [1:0]           chl_i;
  logic [1:0]           fmt_i;
  logic                 busy_o;
  logic                 frame_o;
  logic                 sck_re_o;
  logic                 sck_fe_o;
  logic                 i2s_sck_o;
  logic                 i2s_ws_o;
  state_t               state_dbg_o;

  // Strobes are single-cycle level pulses; no valid/ready handshake exists here.
  modport master (
    input  en_i, div_i, chl_i, fmt_i,
    output busy_o, frame_o, sck_re_o, sck_fe_o, i2s_sck_o, i2s_ws_o, state_dbg_o
  );

  modport slave (
    output en_i, div_i, chl_i, fmt_i,
    input  busy_o, frame_o, sck_re_o, sck_fe_o, i2s_sck_o, i2s_ws_o, state_dbg_o
  );
endinterface

// File: rtl/i2s_clkdiv.sv
// SCK divider: counts 0..div_i, toggles sck at terminal count, emits edge strobes.
module i2s_clkdiv #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sck_o,
  output logic                 re_o,
  output logic                 fe_o,
  output logic                 fall_tick_o
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sck_q, sck_d;
  logic                 re_q, re_d;
  logic                 fe_q, fe_d;
  logic                 term;

  assign term = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    re_d  = 1'b0;
    fe_d  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (en_i) begin
      if (term) begin
        cnt_d = '0;
        sck_d = ~sck_q;
        re_d  = ~sck_q;
        fe_d  = sck_q;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
      re_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
      re_q  <= re_d;
      fe_q  <= fe_d;
    end
  end

  // High in the cycle before sck falls, so the slot logic updates on the same edge.
  assign fall_tick_o = en_i && !clr_i && term && sck_q;
  assign sck_o       = sck_q;
  assign re_o        = re_q;
  assign fe_o        = fe_q;
endmodule

// File: rtl/i2s_clkgen.sv
// I2S master bit/word clock generator: run/stop FSM, slot counter and WS alignment.
module i2s_clkgen
  import i2s_clkgen_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  i2s_clkgen_if.master bus
);
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [5:0]           last_q, last_d;
  logic                 lj_q, lj_d;
  logic [5:0]           k_q, k_d;
  logic                 ws_q, ws_d;
  logic                 frame_q, frame_d;
  logic [5:0]           k_nxt;
  logic                 lj_in;
  logic                 div_clr;
  logic                 fall_tick;
  logic                 sck, sck_re, sck_fe;

  assign lj_in   = (bus.fmt_i == I2S_FMT_LJ);
  assign div_clr = (state_q == I2S_CLKGEN_IDLE);
  assign k_nxt   = (k_q == last_q) ? 6'd0 : k_q + 6'd1;

  i2s_clkdiv #(.DIV_WIDTH(DIV_WIDTH)) u_clkdiv (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (!div_clr),
    .clr_i       (div_clr),
    .div_i       (div_q),
    .sck_o       (sck),
    .re_o        (sck_re),
    .fe_o        (sck_fe),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    last_d  = last_q;
    lj_d    = lj_q;
    k_d     = k_q;
    ws_d    = ws_q;
    frame_d = 1'b0;
    case (state_q)
      I2S_CLKGEN_IDLE: begin
        k_d  = 6'd0;
        ws_d = !lj_in;
        if (bus.en_i) begin
          state_d = I2S_CLKGEN_RUN;
          div_d   = bus.div_i;
          last_d  = slot_last(bus.chl_i);
          lj_d    = lj_in;
          ws_d    = lj_in;
          frame_d = 1'b1;
        end
      end
      default: begin
        if (state_q == I2S_CLKGEN_RUN && !bus.en_i) state_d = I2S_CLKGEN_STOP;
        if (state_q == I2S_CLKGEN_STOP && bus.en_i) state_d = I2S_CLKGEN_RUN;
        if (fall_tick) begin
          k_d  = k_nxt;
          ws_d = ws_level(lj_q, k_nxt, last_q);
          if (k_nxt == 6'd0) begin
            // A stop request completes exactly at the frame boundary.
            if (state_q == I2S_CLKGEN_STOP && !bus.en_i) begin
              state_d = I2S_CLKGEN_IDLE;
              ws_d    = !lj_in;
            end else begin
              frame_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= I2S_CLKGEN_IDLE;
      div_q   <= '0;
      last_q  <= 6'd15;
      lj_q    <= 1'b0;
      k_q     <= 6'd0;
      ws_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      last_q  <= last_d;
      lj_q    <= lj_d;
      k_q     <= k_d;
      ws_q    <= ws_d;
      frame_q <= frame_d;
    end
  end

  assign bus.busy_o      = (state_q != I2S_CLKGEN_IDLE);
  assign bus.frame_o     = frame_q;
  assign bus.sck_re_o    = sck_re;
  assign bus.sck_fe_o    = sck_fe;
  assign bus.i2s_sck_o   = sck;
  assign bus.i2s_ws_o    = ws_q;
  assign bus.state_dbg_o = state_q;
endmodule
